// File: rtl/clock_pkg.sv
// Shared types and constants for the time-of-day / alarm block.
// Field limits and alarm-slot layout live here so every file clamps the same way.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EDIT = 2'd2
    } state_t;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    typedef struct packed {
        logic              en;
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
    } alarm_slot_t;

    function automatic logic [MIN_W-1:0] clamp_59(input logic [MIN_W-1:0] v);
        return (v > MIN_MAX) ? MIN_MAX : v;
    endfunction

    function automatic logic [HOUR_W-1:0] clamp_hour(input logic [HOUR_W-1:0] v);
        return (v > HOUR_MAX) ? HOUR_MAX : v;
    endfunction

endpackage

// File: rtl/clock_prescaler.sv
// Divides clk down to a one-second tick; held at zero whenever the clock is not running
// so every pause or edit restarts a full second.
module clock_prescaler #(
    parameter int CLK_FRQ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(CLK_FRQ);
    localparam logic [CW-1:0] LAST = CW'(CLK_FRQ - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !run)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/clock_alarm.sv
// 24 h time-of-day counter with IDLE/RUN/EDIT control, optional 12 h display,
// and N_ALARM programmable HH:MM alarms with sticky, individually acked ring flags.
module clock_alarm
    import clock_pkg::*;
#(
    parameter  int CLK_FRQ = 100_000_000,
    parameter  int N_ALARM = 4,
    localparam int SW      = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              edit,
    input  logic [HOUR_W-1:0] e_hour,
    input  logic [MIN_W-1:0]  e_minute,
    input  logic [SEC_W-1:0]  e_sec,
    input  logic              mode_12h,
    input  logic              alarm_wr,
    input  logic [SW-1:0]     alarm_sel,
    input  logic              alarm_en,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MIN_W-1:0]  alarm_minute,
    input  logic [N_ALARM-1:0] alarm_ack,
    output logic [SEC_W-1:0]  second,
    output logic [MIN_W-1:0]  minute,
    output logic [HOUR_W-1:0] hour,
    output logic              pm,
    output logic              idle_mode,
    output logic              run_mode,
    output logic              edit_mode,
    output logic              sec_tick,
    output logic [N_ALARM-1:0] alarm_ring
);

    state_t            state;
    logic              tick;
    logic [HOUR_W-1:0] hr;

    // Control FSM; mode outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            {edit_mode, run_mode, idle_mode} <= 3'b001;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (edit) begin
                        state <= ST_EDIT;
                        {edit_mode, run_mode, idle_mode} <= 3'b100;
                    end else if (start) begin
                        state <= ST_RUN;
                        {edit_mode, run_mode, idle_mode} <= 3'b010;
                    end
                end
                ST_RUN: begin
                    if (edit) begin
                        state <= ST_EDIT;
                        {edit_mode, run_mode, idle_mode} <= 3'b100;
                    end else if (stop) begin
                        state <= ST_IDLE;
                        {edit_mode, run_mode, idle_mode} <= 3'b001;
                    end
                end
                ST_EDIT: begin
                    if (!edit) begin
                        state <= ST_IDLE;
                        {edit_mode, run_mode, idle_mode} <= 3'b001;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    {edit_mode, run_mode, idle_mode} <= 3'b001;
                end
            endcase
        end
    end

    clock_prescaler #(.CLK_FRQ(CLK_FRQ)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (state == ST_RUN),
        .tick (tick)
    );

    logic              sec_wrap, min_wrap;
    logic [SEC_W-1:0]  nsec;
    logic [MIN_W-1:0]  nmin;
    logic [HOUR_W-1:0] nhr;

    assign sec_wrap = (second == SEC_MAX);
    assign min_wrap = (minute == MIN_MAX);
    assign nsec     = sec_wrap ? '0 : second + 1'b1;
    assign nmin     = sec_wrap ? (min_wrap ? '0 : minute + 1'b1) : minute;
    assign nhr      = (sec_wrap && min_wrap) ? ((hr == HOUR_MAX) ? '0 : hr + 1'b1) : hr;

    always_ff @(posedge clk) begin
        if (rst) begin
            second   <= '0;
            minute   <= '0;
            hr       <= '0;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= tick;
            if (state == ST_EDIT) begin
                second <= clamp_59(e_sec);
                minute <= clamp_59(e_minute);
                hr     <= clamp_hour(e_hour);
            end else if (tick) begin
                second <= nsec;
                minute <= nmin;
                hr     <= nhr;
            end
        end
    end

    // Only the tick that lands on HH:MM:00 can match; compare against the slot's pre-write value
    for (genvar i = 0; i < N_ALARM; i++) begin : g_alarm
        alarm_slot_t slot;
        logic        ring_q;
        logic        sel_hit, match, clr;

        assign sel_hit = alarm_wr && (alarm_sel == SW'(i));
        assign match   = tick && sec_wrap && slot.en &&
                         (slot.hour == nhr) && (slot.minute == nmin);
        assign clr     = alarm_ack[i] || (sel_hit && !alarm_en);

        always_ff @(posedge clk) begin
            if (rst) begin
                slot   <= '0;
                ring_q <= 1'b0;
            end else begin
                if (sel_hit)
                    slot <= '{en: alarm_en, hour: clamp_hour(alarm_hour),
                              minute: clamp_59(alarm_minute)};
                ring_q <= match || (ring_q && !clr);
            end
        end

        assign alarm_ring[i] = ring_q;
    end

    always_comb begin
        hour = hr;
        if (mode_12h) begin
            if (hr == '0)
                hour = 5'd12;
            else if (hr > 5'd12)
                hour = hr - 5'd12;
        end
    end

    assign pm = (hr >= 5'd12);

endmodule

// File: tb/tb_clock_alarm.sv
// Bench for clock_alarm: edit-clamp vector table, directed corner sequences and
// random stimulus checked cycle by cycle against a seconds-of-day reference model.
module tb_clock_alarm;

    localparam int CLK_FRQ = 10;
    localparam int N_ALARM = 4;
    localparam int SW      = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0, stop = 1'b0, edit = 1'b0;
    logic [4:0]        e_hour = '0;
    logic [5:0]        e_minute = '0, e_sec = '0;
    logic              mode_12h = 1'b0;
    logic              alarm_wr = 1'b0;
    logic [SW-1:0]     alarm_sel = '0;
    logic              alarm_en = 1'b0;
    logic [4:0]        alarm_hour = '0;
    logic [5:0]        alarm_minute = '0;
    logic [N_ALARM-1:0] alarm_ack = '0;
    logic [5:0]        second, minute;
    logic [4:0]        hour;
    logic              pm, idle_mode, run_mode, edit_mode, sec_tick;
    logic [N_ALARM-1:0] alarm_ring;

    clock_alarm #(.CLK_FRQ(CLK_FRQ), .N_ALARM(N_ALARM)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .edit(edit),
        .e_hour(e_hour), .e_minute(e_minute), .e_sec(e_sec), .mode_12h(mode_12h),
        .alarm_wr(alarm_wr), .alarm_sel(alarm_sel), .alarm_en(alarm_en),
        .alarm_hour(alarm_hour), .alarm_minute(alarm_minute), .alarm_ack(alarm_ack),
        .second(second), .minute(minute), .hour(hour), .pm(pm),
        .idle_mode(idle_mode), .run_mode(run_mode), .edit_mode(edit_mode),
        .sec_tick(sec_tick), .alarm_ring(alarm_ring)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: time kept as seconds since midnight, state as 0 idle / 1 run / 2 edit
    int m_st = 0, m_t = 0, m_ph = 0;
    int a_en[N_ALARM], a_h[N_ALARM], a_m[N_ALARM];
    bit m_ring[N_ALARM];
    bit m_tick = 0;

    function automatic int clip(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic model_step();
        bit tk, set, clr;
        if (rst) begin
            m_st = 0; m_t = 0; m_ph = 0; m_tick = 0;
            for (int i = 0; i < N_ALARM; i++) begin
                a_en[i] = 0; a_h[i] = 0; a_m[i] = 0; m_ring[i] = 0;
            end
            return;
        end
        tk = (m_st == 1) && (m_ph == CLK_FRQ - 1);
        m_ph = (m_st == 1) ? (m_ph + 1) % CLK_FRQ : 0;
        m_tick = tk;
        if (m_st == 2)
            m_t = clip(int'(e_hour), 23) * 3600 + clip(int'(e_minute), 59) * 60 + clip(int'(e_sec), 59);
        else if (tk)
            m_t = (m_t + 1) % 86400;
        for (int i = 0; i < N_ALARM; i++) begin
            set = tk && (m_t % 60 == 0) && (a_en[i] != 0) && (m_t / 60 == a_h[i] * 60 + a_m[i]);
            clr = alarm_ack[i] || (alarm_wr && int'(alarm_sel) == i && !alarm_en);
            m_ring[i] = set || (m_ring[i] && !clr);
        end
        if (alarm_wr && int'(alarm_sel) < N_ALARM) begin
            a_en[alarm_sel] = int'(alarm_en);
            a_h[alarm_sel]  = clip(int'(alarm_hour), 23);
            a_m[alarm_sel]  = clip(int'(alarm_minute), 59);
        end
        case (m_st)
            0: m_st = edit ? 2 : (start ? 1 : 0);
            1: m_st = edit ? 2 : (stop ? 0 : 1);
            default: m_st = edit ? 2 : 0;
        endcase
    endtask

    task automatic check_model();
        int h24;
        logic [N_ALARM-1:0] r;
        h24 = m_t / 3600;
        for (int i = 0; i < N_ALARM; i++) r[i] = m_ring[i];
        chk("second", second, m_t % 60);
        chk("minute", minute, (m_t / 60) % 60);
        chk("hour", hour, mode_12h ? ((h24 + 11) % 12 + 1) : h24);
        chk("pm", pm, h24 >= 12);
        chk("idle_mode", idle_mode, m_st == 0);
        chk("run_mode", run_mode, m_st == 1);
        chk("edit_mode", edit_mode, m_st == 2);
        chk("sec_tick", sec_tick, m_tick);
        chk("alarm_ring", alarm_ring, r);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic run_n(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_edit(input int h, input int m, input int s);
        e_hour = 5'(h); e_minute = 6'(m); e_sec = 6'(s);
        edit = 1'b1;
        cycle();
        cycle();
        edit = 1'b0;
        cycle();
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic write_slot(input int sel, input bit en, input int h, input int m);
        alarm_wr = 1'b1; alarm_sel = SW'(sel); alarm_en = en;
        alarm_hour = 5'(h); alarm_minute = 6'(m);
        cycle();
        alarm_wr = 1'b0;
    endtask

    typedef struct {
        int eh, em, es;
        bit m12;
        int xh, xm, xs, xpm;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int sv_s, sv_m;
        tbl[0] = '{30, 63, 63, 1'b0, 23, 59, 59, 1};
        tbl[1] = '{30, 63, 63, 1'b1, 11, 59, 59, 1};
        tbl[2] = '{0,  0,  0,  1'b1, 12, 0,  0,  0};
        tbl[3] = '{12, 5,  7,  1'b1, 12, 5,  7,  1};
        tbl[4] = '{13, 0,  0,  1'b1, 1,  0,  0,  1};
        tbl[5] = '{7,  30, 0,  1'b0, 7,  30, 0,  0};
        tbl[6] = '{24, 60, 60, 1'b0, 23, 59, 59, 1};
        tbl[7] = '{11, 59, 59, 1'b1, 11, 59, 59, 0};

        // Reset, then idle: no ticks
        rst = 1'b1;
        run_n(2);
        chk("rst_time", {hour, minute, second}, 0);
        chk("rst_idle", idle_mode, 1);
        chk("rst_ring", alarm_ring, 0);
        rst = 1'b0;
        run_n(15);

        // Edit clamping / 12 h conversion table
        foreach (tbl[k]) begin
            mode_12h = tbl[k].m12;
            do_edit(tbl[k].eh, tbl[k].em, tbl[k].es);
            chk("tbl_hour", hour, tbl[k].xh);
            chk("tbl_min", minute, tbl[k].xm);
            chk("tbl_sec", second, tbl[k].xs);
            chk("tbl_pm", pm, tbl[k].xpm);
        end
        mode_12h = 1'b0;

        // Midnight rollover
        do_edit(23, 59, 55);
        do_start();
        run_n(50);
        chk("midnight", {hour, minute, second}, 0);
        mode_12h = 1'b1;
        #1;
        chk("midnight_12h", hour, 12);
        chk("midnight_pm", pm, 0);
        do_edit(13, 0, 0);
        chk("h13_12h", hour, 1);
        chk("h13_pm", pm, 1);
        mode_12h = 1'b0;

        // Alarm ring exactly on the 07:30:00 tick, ack, and edit-load non-trigger
        write_slot(2, 1'b1, 7, 30);
        do_edit(7, 29, 58);
        do_start();
        run_n(19);
        chk("ring_early", alarm_ring, 0);
        cycle();
        chk("ring_set", alarm_ring, 4'b0100);
        chk("ring_time", {hour, minute, second}, {5'd7, 6'd30, 6'd0});
        alarm_ack = 4'b0100;
        cycle();
        alarm_ack = '0;
        chk("ring_ack", alarm_ring, 0);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        do_edit(7, 30, 0);
        chk("ring_edit", alarm_ring, 0);

        // Pause at prescaler 5, restart takes a full second
        do_start();
        run_n(5);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        sv_s = second; sv_m = minute;
        run_n(20);
        chk("pause_frozen", second, sv_s);
        do_start();
        run_n(9);
        chk("restart_wait", second, sv_s);
        cycle();
        chk("restart_inc", second, (sv_s + 1) % 60);
        chk("restart_min", minute, (sv_s == 59) ? (sv_m + 1) % 60 : sv_m);

        // Edit beats start; clamping
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        edit = 1'b1; start = 1'b1;
        e_hour = 5'd30; e_minute = 6'd10; e_sec = 6'd63;
        cycle();
        chk("prio_edit", edit_mode, 1);
        chk("prio_run", run_mode, 0);
        cycle();
        chk("clamp_sec", second, 59);
        chk("clamp_hour", hour, 23);
        edit = 1'b0; start = 1'b0;
        cycle();

        // Reset while ringing in RUN
        write_slot(2, 1'b1, 7, 30);
        do_edit(7, 29, 58);
        do_start();
        run_n(20);
        chk("ring_pre_rst", alarm_ring, 4'b0100);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_run_time", {hour, minute, second}, 0);
        chk("rst_run_idle", idle_mode, 1);
        chk("rst_run_ring", alarm_ring, 0);
        chk("rst_run_tick", sec_tick, 0);
        do_edit(7, 29, 58);
        do_start();
        run_n(20);
        chk("slot_cleared", alarm_ring, 0);

        // Randomized stimulus against the model
        for (int n = 0; n < 2500; n++) begin
            rst   = ($urandom_range(0, 499) == 0);
            start = ($urandom_range(0, 4) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            edit  = ($urandom_range(0, 49) == 0);
            e_hour   = 5'($urandom_range(0, 31));
            e_minute = 6'($urandom_range(0, 63));
            e_sec    = 6'($urandom_range(50, 63));
            if ($urandom_range(0, 29) == 0) mode_12h = ~mode_12h;
            alarm_wr  = ($urandom_range(0, 19) == 0);
            alarm_sel = SW'($urandom_range(0, N_ALARM - 1));
            alarm_en  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                alarm_hour   = 5'(m_t / 3600);
                alarm_minute = 6'(((m_t / 60) % 60 + 1) % 60);
            end else begin
                alarm_hour   = 5'($urandom_range(0, 31));
                alarm_minute = 6'($urandom_range(0, 63));
            end
            alarm_ack = ($urandom_range(0, 9) == 0) ? N_ALARM'($urandom) : '0;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
